mc_controller_ext: RTL and testbench
====================================

# mc_controller_ext

Parametrised successor to the multicycle MIPS `controller`. It combines a Moore main FSM with a combinational ALU decoder. It adds immediate-ALU ops (addi/andi/ori), bne, j, an illegal-opcode trap and a debug state output. It sits between the instruction register (op/funct) and the multicycle datapath, keeping the base output bundle unchanged so existing 15-bit vector benches still apply.

## Interface
- EXT_OPS, 1, 1 enables addi/andi/ori/bne/j; 0 treats those opcodes as illegal (base ISA: lw, sw, R-type, beq)
- ILLEGAL_TRAP, 1, 1 = illegal opcode parks FSM in TRAP until reset; 0 = skip the instruction and return to FETCH
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  6  instr[31:26], stable from DECODE until next FETCH
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst  output  1 each  datapath controls
- alusrcb  output  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- pcsrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- zeroext  output  1  1 = zero-extend immediate (andi/ori)
- illegal  output  1  high while in TRAP, or for the one DECODE cycle that skips an instruction
- state  output  4  current FSM state, debug

## Operation
- States (4-bit encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQ 8, IMMEX 9, IMMWB 10, JUMP 11, BNE 12, TRAP 15. Codes 13 and 14 are unused; if reached, the next state is FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op:
    - lw 100011 / sw 101011 → MEMADR.
    - R 000000 → EXECUTE.
    - beq 000100 → BEQ.
    - bne 000101 → BNE.
    - addi 001000 / andi 001100 / ori 001101 → IMMEX.
    - j 000010 → JUMP.
    - any other op → TRAP or FETCH, per ILLEGAL_TRAP.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB, EXECUTE→ALUWB, IMMEX→IMMWB.
  - MEMWB, MEMWR, ALUWB, IMMWB, BEQ, BNE, JUMP → FETCH.
  - TRAP→TRAP.
- Moore outputs (unlisted = 0):
  - FETCH: irwrite, pcwrite, alusrcb=01, aluop add.
  - DECODE: alusrcb=11, aluop add.
  - MEMADR: alusrca, alusrcb=10, aluop add.
  - MEMRD: iord.
  - MEMWB: memtoreg, regwrite.
  - MEMWR: iord, memwrite.
  - EXECUTE: alusrca, aluop funct.
  - ALUWB: regdst, regwrite.
  - BEQ: alusrca, aluop sub, pcsrc=01, branch.
  - BNE: alusrca, aluop sub, pcsrc=01, branchne.
  - IMMEX: alusrca, alusrcb=10, aluop op; zeroext for andi/ori.
  - IMMWB: regwrite.
  - JUMP: pcsrc=10, pcwrite.
  - TRAP: illegal.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero). zero is combinational and is sampled in the same cycle.
- ALU decoder (internal aluop):
  - add → 010.
  - sub → 110.
  - funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→010.
  - op: 001000→010, 001100→000, 001101→001.

## Timing
- Reset asserts asynchronously and forces state=FETCH immediately, mid-instruction included. Outputs while reset is held equal the FETCH outputs: pcen=1, irwrite=1, alusrcb=01, alucontrol=010, all else 0; bundle 0x5022.
- FSM leaves FETCH on the first rising edge after reset deasserts.
- Cycles per instruction, FETCH inclusive: lw 5; sw, R-type, imm 4; beq, bne, j 3; illegal with ILLEGAL_TRAP=0 is 2.
- op changes outside DECODE, MEMADR and IMMEX have no effect on the transition.
- With EXT_OPS=0, opcodes 000101, 001000, 001100, 001101 and 000010 follow the illegal path.

## Test plan
- Output bundle order: {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol}.
- Reset held, op=100011 → state=0, bundle=0x5022; release → next edge state=1, bundle=0x0062.
- lw (op 100011): states 0,1,2,3,4,0. In MEMWB regwrite=1, memtoreg=1. sw: states 0,1,2,5,0 with memwrite=1 only in MEMWR.
- R-type funct 100010, 101010, 100101 → EXECUTE alucontrol 110, 111, 001; ALUWB regdst=1, regwrite=1.
- beq with zero=1 → BEQ pcen=1, pcsrc=01. bne with zero=1 → pcen=0; bne with zero=0 → pcen=1.
- ori (001101) → IMMEX alucontrol=001, zeroext=1, alusrcb=10; IMMWB regwrite=1, regdst=0. j → JUMP pcsrc=10, pcen=1, then FETCH.
- op 111111, ILLEGAL_TRAP=1 → state 15 with illegal=1 held 10 cycles, reset → FETCH. Repeat with ILLEGAL_TRAP=0 → DECODE illegal pulse, then FETCH. EXT_OPS=0 with op 001000 → illegal path. Reset asserted in MEMRD → state 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS controller: Moore main FSM plus ALU decoder, extended with
// addi/andi/ori, bne, j, illegal-opcode trap/skip and a debug state port.
module mc_controller_ext #(
  parameter bit EXT_OPS      = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       zeroext,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12,
    S_TRAP    = 4'd15
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       zeroext;
    logic       trap;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;
  localparam logic [1:0] AOP_OP  = 2'b11;

  localparam state_t ILLEGAL_NEXT = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [5:0] o,
                                            input logic [5:0] f);
    logic [2:0] r;
    case (aluop)
      AOP_ADD: r = 3'b010;
      AOP_SUB: r = 3'b110;
      AOP_FN: begin
        case (f)
          6'b100000: r = 3'b010;
          6'b100010: r = 3'b110;
          6'b100100: r = 3'b000;
          6'b100101: r = 3'b001;
          6'b101010: r = 3'b111;
          default:   r = 3'b010;
        endcase
      end
      AOP_OP: begin
        case (o)
          OP_ADDI: r = 3'b010;
          OP_ANDI: r = 3'b000;
          OP_ORI:  r = 3'b001;
          default: r = 3'b010;
        endcase
      end
      default: r = 3'b010;
    endcase
    return r;
  endfunction

  // Moore output decode for the state being entered; op/funct are valid then.
  function automatic ctl_t ctl_for(input state_t s, input logic [5:0] o,
                                   input logic [5:0] f);
    ctl_t       c;
    logic [1:0] aluop;
    c     = '0;
    aluop = AOP_ADD;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        aluop     = AOP_FN;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 1'b1;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
        aluop     = AOP_SUB;
      end
      S_BNE: begin
        c.alusrca  = 1'b1;
        c.pcsrc    = 2'b01;
        c.branchne = 1'b1;
        aluop      = AOP_SUB;
      end
      S_IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.zeroext = (o == OP_ANDI) || (o == OP_ORI);
        aluop     = AOP_OP;
      end
      S_IMMWB:   c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      S_TRAP:    c.trap = 1'b1;
      default:   aluop = AOP_ADD;
    endcase
    c.alucontrol = alu_decode(aluop, o, f);
    return c;
  endfunction

  state_t state_r;
  state_t next_s;
  ctl_t   ctl_r;
  logic   skip_s;

  // Next-state logic
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: next_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:             next_s = S_MEMADR;
          OP_RTYPE:                 next_s = S_EXECUTE;
          OP_BEQ:                   next_s = S_BEQ;
          OP_BNE:                   next_s = EXT_OPS ? S_BNE : ILLEGAL_NEXT;
          OP_ADDI, OP_ANDI, OP_ORI: next_s = EXT_OPS ? S_IMMEX : ILLEGAL_NEXT;
          OP_J:                     next_s = EXT_OPS ? S_JUMP : ILLEGAL_NEXT;
          default:                  next_s = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR: next_s = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_s = S_MEMWB;
      S_EXECUTE: next_s = S_ALUWB;
      S_IMMEX:   next_s = S_IMMWB;
      S_TRAP:    next_s = S_TRAP;
      default:   next_s = S_FETCH;
    endcase
  end

  // State register with registered Moore outputs; reset loads FETCH outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
      ctl_r   <= ctl_for(S_FETCH, 6'd0, 6'd0);
    end else begin
      state_r <= next_s;
      ctl_r   <= ctl_for(next_s, op, funct);
    end
  end

  // DECODE only falls back to FETCH when an instruction is being skipped
  assign skip_s = !ILLEGAL_TRAP && (state_r == S_DECODE) && (next_s == S_FETCH);

  assign pcen       = ctl_r.pcwrite | (ctl_r.branch & zero) | (ctl_r.branchne & ~zero);
  assign memwrite   = ctl_r.memwrite;
  assign irwrite    = ctl_r.irwrite;
  assign regwrite   = ctl_r.regwrite;
  assign alusrca    = ctl_r.alusrca;
  assign iord       = ctl_r.iord;
  assign memtoreg   = ctl_r.memtoreg;
  assign regdst     = ctl_r.regdst;
  assign alusrcb    = ctl_r.alusrcb;
  assign pcsrc      = ctl_r.pcsrc;
  assign alucontrol = ctl_r.alucontrol;
  assign zeroext    = ctl_r.zeroext;
  assign illegal    = ctl_r.trap | skip_s;
  assign state      = state_r;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Directed bench for mc_controller_ext: three instances cover the default,
// skip-on-illegal and base-ISA-only configurations on shared inputs.
module tb_mc_controller_ext;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       pcen[3], memwrite[3], irwrite[3], regwrite[3];
  logic       alusrca[3], iord[3], memtoreg[3], regdst[3];
  logic [1:0] alusrcb[3], pcsrc[3];
  logic [2:0] alucontrol[3];
  logic       zeroext[3], illegal[3];
  logic [3:0] state[3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_controller_ext #(.EXT_OPS(1'b1), .ILLEGAL_TRAP(1'b1)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen[0]), .memwrite(memwrite[0]), .irwrite(irwrite[0]), .regwrite(regwrite[0]),
    .alusrca(alusrca[0]), .iord(iord[0]), .memtoreg(memtoreg[0]), .regdst(regdst[0]),
    .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]), .alucontrol(alucontrol[0]),
    .zeroext(zeroext[0]), .illegal(illegal[0]), .state(state[0]));

  mc_controller_ext #(.EXT_OPS(1'b1), .ILLEGAL_TRAP(1'b0)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen[1]), .memwrite(memwrite[1]), .irwrite(irwrite[1]), .regwrite(regwrite[1]),
    .alusrca(alusrca[1]), .iord(iord[1]), .memtoreg(memtoreg[1]), .regdst(regdst[1]),
    .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]), .alucontrol(alucontrol[1]),
    .zeroext(zeroext[1]), .illegal(illegal[1]), .state(state[1]));

  mc_controller_ext #(.EXT_OPS(1'b0), .ILLEGAL_TRAP(1'b1)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen[2]), .memwrite(memwrite[2]), .irwrite(irwrite[2]), .regwrite(regwrite[2]),
    .alusrca(alusrca[2]), .iord(iord[2]), .memtoreg(memtoreg[2]), .regdst(regdst[2]),
    .alusrcb(alusrcb[2]), .pcsrc(pcsrc[2]), .alucontrol(alucontrol[2]),
    .zeroext(zeroext[2]), .illegal(illegal[2]), .state(state[2]));

  function automatic logic [15:0] bund0();
    return {1'b0, pcen[0], memwrite[0], irwrite[0], regwrite[0], alusrca[0], iord[0],
            memtoreg[0], regdst[0], alusrcb[0], pcsrc[0], alucontrol[0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Wait for the next falling edge, then compare dut0 state and output bundle
  task automatic expect_st(input string tag, input logic [3:0] s, input logic [15:0] b);
    @(negedge clk);
    check({tag, "_state"}, {12'd0, state[0]}, {12'd0, s});
    check({tag, "_bundle"}, bund0(), b);
  endtask

  logic [5:0]  r_funct [3] = '{6'b100010, 6'b101010, 6'b100101};
  logic [15:0] r_bus   [3] = '{16'h0406, 16'h0407, 16'h0401};

  initial begin
    reset = 1'b1;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", {12'd0, state[0]}, 16'd0);
    check("rst_bundle", bund0(), 16'h5022);
    reset = 1'b0;

    // lw
    expect_st("lw_dec", 4'd1, 16'h0062);
    expect_st("lw_adr", 4'd2, 16'h0442);
    expect_st("lw_rd",  4'd3, 16'h0202);
    expect_st("lw_wb",  4'd4, 16'h0902);
    expect_st("lw_fet", 4'd0, 16'h5022);

    // sw
    op = 6'b101011;
    expect_st("sw_dec", 4'd1, 16'h0062);
    expect_st("sw_adr", 4'd2, 16'h0442);
    expect_st("sw_wr",  4'd5, 16'h2202);
    expect_st("sw_fet", 4'd0, 16'h5022);

    // R-type
    op = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      funct = r_funct[i];
      expect_st("r_dec", 4'd1, 16'h0062);
      expect_st("r_ex",  4'd6, r_bus[i]);
      expect_st("r_wb",  4'd7, 16'h0882);
      expect_st("r_fet", 4'd0, 16'h5022);
    end

    // beq taken, bne not taken, bne taken
    op = 6'b000100; zero = 1'b1;
    expect_st("beq_dec", 4'd1, 16'h0062);
    expect_st("beq_br",  4'd8, 16'h440E);
    expect_st("beq_fet", 4'd0, 16'h5022);
    op = 6'b000101; zero = 1'b1;
    expect_st("bne1_dec", 4'd1, 16'h0062);
    expect_st("bne1_br",  4'd12, 16'h040E);
    expect_st("bne1_fet", 4'd0, 16'h5022);
    zero = 1'b0;
    expect_st("bne0_dec", 4'd1, 16'h0062);
    expect_st("bne0_br",  4'd12, 16'h440E);
    expect_st("bne0_fet", 4'd0, 16'h5022);

    // ori
    op = 6'b001101;
    expect_st("ori_dec", 4'd1, 16'h0062);
    check("ori_dec_zext", {15'd0, zeroext[0]}, 16'd0);
    expect_st("ori_ex",  4'd9, 16'h0441);
    check("ori_ex_zext", {15'd0, zeroext[0]}, 16'd1);
    expect_st("ori_wb",  4'd10, 16'h0802);
    expect_st("ori_fet", 4'd0, 16'h5022);

    // j
    op = 6'b000010;
    expect_st("j_dec", 4'd1, 16'h0062);
    expect_st("j_jmp", 4'd11, 16'h4012);
    expect_st("j_fet", 4'd0, 16'h5022);

    // illegal opcode: dut0 traps, dut1 skips
    op = 6'b111111;
    @(negedge clk);
    check("ill_dec_st0",  {12'd0, state[0]}, 16'd1);
    check("ill_dec_ill0", {15'd0, illegal[0]}, 16'd0);
    check("ill_dec_st1",  {12'd0, state[1]}, 16'd1);
    check("ill_dec_ill1", {15'd0, illegal[1]}, 16'd1);
    @(negedge clk);
    check("skip_fet_st1",  {12'd0, state[1]}, 16'd0);
    check("skip_fet_ill1", {15'd0, illegal[1]}, 16'd0);
    check("skip_fet_bus1", {15'd0, pcen[1]}, 16'd1);
    check("trap_st",  {12'd0, state[0]}, 16'd15);
    check("trap_ill", {15'd0, illegal[0]}, 16'd1);
    check("trap_bus", bund0(), 16'h0002);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("trap_hold_st",  {12'd0, state[0]}, 16'd15);
      check("trap_hold_ill", {15'd0, illegal[0]}, 16'd1);
    end
    #2 reset = 1'b1;
    #1;
    check("trap_rst_st",  {12'd0, state[0]}, 16'd0);
    check("trap_rst_ill", {15'd0, illegal[0]}, 16'd0);
    check("trap_rst_bus", bund0(), 16'h5022);

    // addi with EXT_OPS=0 goes down the illegal path
    @(negedge clk);
    op = 6'b001000;
    reset = 1'b0;
    @(negedge clk);
    check("base_dec_st2", {12'd0, state[2]}, 16'd1);
    @(negedge clk);
    check("base_trap_st2",  {12'd0, state[2]}, 16'd15);
    check("base_trap_ill2", {15'd0, illegal[2]}, 16'd1);
    check("addi_ex_st0",    {12'd0, state[0]}, 16'd9);
    check("addi_ex_bus0",   bund0(), 16'h0442);
    check("addi_ex_zext0",  {15'd0, zeroext[0]}, 16'd0);

    // asynchronous reset in the middle of lw
    reset = 1'b1;
    op = 6'b100011;
    @(negedge clk);
    reset = 1'b0;
    expect_st("lw2_dec", 4'd1, 16'h0062);
    expect_st("lw2_adr", 4'd2, 16'h0442);
    expect_st("lw2_rd",  4'd3, 16'h0202);
    #2 reset = 1'b1;
    #1;
    check("memrd_rst_st",  {12'd0, state[0]}, 16'd0);
    check("memrd_rst_bus", bund0(), 16'h5022);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
